sar_search_4bit: RTL and testbench

Successive-approximation controller that recovers an unknown operand A, bit by bit, from magnitude-comparator flags. It drives trial values onto the comparator's B input and reads EQ/AGB/ALB back. It is the inverse side of the team's 4-bit magnitude comparator: that block turns (A,B) into flags, and this block turns flags into A. It is used for threshold/level search and for closed-loop self-test of the comparator.

---
 rtl/sar_search_4bit.sv | 127 ++++++++++++
 tb/tb_sar_search_4bit.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sar_search_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : sar_search_4bit
//  Purpose  : Successive-approximation controller. Drives trial values onto a
//             magnitude comparator's B input and rebuilds the unknown operand
//             A from the EQ/AGB/ALB flags, one bit per trial, MSB first.
//  Revision : 1.0 - initial release
// ============================================================================
module sar_search_4bit #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             cmp_eq,
   input  logic             cmp_agb,
   input  logic             cmp_alb,
   output logic [WIDTH-1:0] guess,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             found,
   output logic             err
);

   localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   localparam logic [WIDTH-1:0] C_MSB     = WIDTH'(1) << (WIDTH - 1);
   localparam logic [IDX_W-1:0] C_TOP_IDX = IDX_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SETTLE = 2'd1,
      S_EVAL   = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   state_t           r_state;
   logic [IDX_W-1:0] r_index;

   logic [WIDTH-1:0] w_cur_mask;
   logic [WIDTH-1:0] w_next_mask;
   logic [WIDTH-1:0] w_trial;
   logic             w_flags_ok;

   // Bit currently under test, and the next lower bit to try.
   assign w_cur_mask  = WIDTH'(1) << r_index;
   assign w_next_mask = w_cur_mask >> 1;

   // A below the guess means the trial bit was too large: drop it.
   assign w_trial = cmp_alb ? (guess & ~w_cur_mask) : guess;

   // Exactly one flag high: odd parity rules out two set, the AND rules out three.
   assign w_flags_ok = (cmp_eq ^ cmp_agb ^ cmp_alb) & ~(cmp_eq & cmp_agb & cmp_alb);

   // Search state machine; every output is registered here.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_index <= C_TOP_IDX;
         guess   <= '0;
         result  <= '0;
         found   <= 1'b0;
         err     <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  guess   <= C_MSB;
                  r_index <= C_TOP_IDX;
                  found   <= 1'b0;
                  err     <= 1'b0;
                  busy    <= 1'b1;
                  r_state <= S_SETTLE;
               end
            end

            // Comparator needs one cycle to see the new guess.
            S_SETTLE: begin
               r_state <= S_EVAL;
            end

            S_EVAL: begin
               if (!w_flags_ok) begin
                  err     <= 1'b1;
                  result  <= '0;
                  found   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else if (cmp_eq) begin
                  result  <= guess;
                  found   <= 1'b1;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else if (r_index == '0) begin
                  // Only reachable for A == 0; value is inferred, not confirmed.
                  result  <= w_trial;
                  found   <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  r_state <= S_DONE;
               end else begin
                  guess   <= w_trial | w_next_mask;
                  r_index <= r_index - IDX_W'(1);
                  r_state <= S_SETTLE;
               end
            end

            S_DONE: begin
               r_state <= S_IDLE;
            end

            default: begin
               r_state <= S_IDLE;
               busy    <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sar_search_4bit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sar_search_4bit
//  Purpose  : Directed self-checking bench for sar_search_4bit. A behavioural
//             comparator closes the loop from guess back to the flag inputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sar_search_4bit;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       start = 1'b0;
   logic [3:0] a_val = 4'd0;
   logic       force_zero = 1'b0;

   logic       cmp_eq, cmp_agb, cmp_alb;
   logic [3:0] guess, result;
   logic       busy, done, found, err;

   int passed = 0;
   int total  = 0;

   // Observations gathered by run_search
   int         first_done;
   int         dones;
   int         busy_cnt;
   int         nseq;
   logic [3:0] seq [8];
   logic [3:0] res_d;
   logic       found_d, err_d, err_at1;
   logic [3:0] rs_guess, rs_result;
   logic       rs_busy, rs_done, rs_found, rs_err;

   always #5 clk = ~clk;

   // Behavioural magnitude comparator, with an override that kills all flags.
   assign cmp_eq  = force_zero ? 1'b0 : (a_val == guess);
   assign cmp_agb = force_zero ? 1'b0 : (a_val >  guess);
   assign cmp_alb = force_zero ? 1'b0 : (a_val <  guess);

   sar_search_4bit #(.WIDTH(4)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .start   (start),
      .cmp_eq  (cmp_eq),
      .cmp_agb (cmp_agb),
      .cmp_alb (cmp_alb),
      .guess   (guess),
      .busy    (busy),
      .done    (done),
      .result  (result),
      .found   (found),
      .err     (err)
   );

   // Pulse start, then watch 20 cycles. n=1 is the cycle right after the edge
   // that accepted start. Optional events: second start, flag kill, reset.
   task automatic run_search(input logic [3:0] a, input int restart_at,
                             input int force_at, input int rst_at);
      a_val      = a;
      first_done = -1;
      dones      = 0;
      busy_cnt   = 0;
      nseq       = 0;
      err_at1    = 1'bx;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         start      = (n == restart_at);
         force_zero = (n == force_at);
         if (n == rst_at + 2) rst_n = 1'b1;
         if (n == 1) err_at1 = err;
         if (busy) begin
            busy_cnt++;
            if ((n % 2 == 1) && (nseq < 8)) begin
               seq[nseq] = guess;
               nseq++;
            end
         end
         if (done) begin
            dones++;
            if (first_done < 0) begin
               first_done = n;
               res_d      = result;
               found_d    = found;
               err_d      = err;
            end
         end
         if (n == rst_at) begin
            rst_n = 1'b0;
            #1;
            rs_guess  = guess;
            rs_result = result;
            rs_busy   = busy;
            rs_done   = done;
            rs_found  = found;
            rs_err    = err;
         end
         @(negedge clk);
      end
      start      = 1'b0;
      force_zero = 1'b0;
   endtask

   task automatic test_reset;
      #12;
      total++;
      if ({guess, result, found, err, busy, done} !== 12'h000)
         $display("FAIL reset_vals: got guess=%0d result=%0d found=%b err=%b busy=%b done=%b, want all 0",
                  guess, result, found, err, busy, done);
      else passed++;
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({busy, done} !== 2'b00)
         $display("FAIL idle_quiet: got busy=%b done=%b, want 0 0", busy, done);
      else passed++;
   endtask

   task automatic test_a5;
      run_search(4'd5, -1, -1, -1);
      total++;
      if (nseq !== 4 || seq[0] !== 4'd8 || seq[1] !== 4'd4 || seq[2] !== 4'd6 || seq[3] !== 4'd5)
         $display("FAIL a5_seq: got n=%0d %0d,%0d,%0d,%0d want 4 8,4,6,5", nseq, seq[0], seq[1], seq[2], seq[3]);
      else passed++;
      total++;
      if (first_done !== 9 || dones !== 1)
         $display("FAIL a5_latency: got done at %0d (%0d pulses), want 9 (1)", first_done, dones);
      else passed++;
      total++;
      if (res_d !== 4'd5 || found_d !== 1'b1 || err_d !== 1'b0)
         $display("FAIL a5_result: got res=%0d found=%b err=%b, want 5 1 0", res_d, found_d, err_d);
      else passed++;
      total++;
      if (result !== 4'd5)
         $display("FAIL a5_hold: got result=%0d, want 5", result);
      else passed++;
   endtask

   task automatic test_a8;
      run_search(4'd8, -1, -1, -1);
      total++;
      if (first_done !== 3 || dones !== 1)
         $display("FAIL a8_latency: got done at %0d (%0d pulses), want 3 (1)", first_done, dones);
      else passed++;
      total++;
      if (res_d !== 4'd8 || found_d !== 1'b1 || err_d !== 1'b0)
         $display("FAIL a8_result: got res=%0d found=%b err=%b, want 8 1 0", res_d, found_d, err_d);
      else passed++;
      total++;
      if (busy_cnt !== 2)
         $display("FAIL a8_busy: got %0d busy cycles, want 2", busy_cnt);
      else passed++;
   endtask

   task automatic test_a0;
      run_search(4'd0, -1, -1, -1);
      total++;
      if (nseq !== 4 || seq[0] !== 4'd8 || seq[1] !== 4'd4 || seq[2] !== 4'd2 || seq[3] !== 4'd1)
         $display("FAIL a0_seq: got n=%0d %0d,%0d,%0d,%0d want 4 8,4,2,1", nseq, seq[0], seq[1], seq[2], seq[3]);
      else passed++;
      total++;
      if (first_done !== 9)
         $display("FAIL a0_latency: got done at %0d, want 9", first_done);
      else passed++;
      total++;
      if (res_d !== 4'd0 || found_d !== 1'b0 || err_d !== 1'b0)
         $display("FAIL a0_result: got res=%0d found=%b err=%b, want 0 0 0", res_d, found_d, err_d);
      else passed++;
      total++;
      if (guess !== 4'd1)
         $display("FAIL a0_guess_hold: got guess=%0d, want 1", guess);
      else passed++;
   endtask

   task automatic test_err;
      run_search(4'd6, -1, 2, -1);
      total++;
      if (first_done !== 3 || dones !== 1)
         $display("FAIL err_latency: got done at %0d (%0d pulses), want 3 (1)", first_done, dones);
      else passed++;
      total++;
      if (err_d !== 1'b1 || res_d !== 4'd0 || found_d !== 1'b0)
         $display("FAIL err_result: got err=%b res=%0d found=%b, want 1 0 0", err_d, res_d, found_d);
      else passed++;
      total++;
      if (err !== 1'b1)
         $display("FAIL err_hold: got err=%b, want 1", err);
      else passed++;
   endtask

   task automatic test_a15_restart;
      run_search(4'd15, 3, -1, -1);
      total++;
      if (err_at1 !== 1'b0)
         $display("FAIL err_clear: got err=%b after start, want 0", err_at1);
      else passed++;
      total++;
      if (nseq !== 4 || seq[0] !== 4'd8 || seq[1] !== 4'd12 || seq[2] !== 4'd14 || seq[3] !== 4'd15)
         $display("FAIL a15_seq: got n=%0d %0d,%0d,%0d,%0d want 4 8,12,14,15", nseq, seq[0], seq[1], seq[2], seq[3]);
      else passed++;
      total++;
      if (first_done !== 9 || dones !== 1)
         $display("FAIL a15_no_restart: got done at %0d (%0d pulses), want 9 (1)", first_done, dones);
      else passed++;
      total++;
      if (res_d !== 4'd15 || found_d !== 1'b1 || err_d !== 1'b0)
         $display("FAIL a15_result: got res=%0d found=%b err=%b, want 15 1 0", res_d, found_d, err_d);
      else passed++;
   endtask

   task automatic test_reset_mid;
      run_search(4'd11, -1, -1, 5);
      total++;
      if (nseq < 3 || seq[2] !== 4'd10)
         $display("FAIL mid_trial3: got n=%0d guess=%0d, want third trial 10", nseq, seq[2]);
      else passed++;
      total++;
      if ({rs_guess, rs_result, rs_found, rs_err, rs_busy, rs_done} !== 12'h000)
         $display("FAIL mid_async_reset: got guess=%0d result=%0d found=%b err=%b busy=%b done=%b, want all 0",
                  rs_guess, rs_result, rs_found, rs_err, rs_busy, rs_done);
      else passed++;
      total++;
      if (dones !== 0)
         $display("FAIL mid_no_done: got %0d done pulses, want 0", dones);
      else passed++;
      run_search(4'd11, -1, -1, -1);
      total++;
      if (nseq !== 4 || seq[0] !== 4'd8 || seq[1] !== 4'd12 || seq[2] !== 4'd10 || seq[3] !== 4'd11)
         $display("FAIL a11_seq: got n=%0d %0d,%0d,%0d,%0d want 4 8,12,10,11", nseq, seq[0], seq[1], seq[2], seq[3]);
      else passed++;
      total++;
      if (first_done !== 9 || res_d !== 4'd11 || found_d !== 1'b1 || err_d !== 1'b0)
         $display("FAIL a11_result: got done@%0d res=%0d found=%b err=%b, want 9 11 1 0",
                  first_done, res_d, found_d, err_d);
      else passed++;
   endtask

   initial begin
      test_reset;
      test_a5;
      test_a8;
      test_a0;
      test_err;
      test_a15_restart;
      test_reset_mid;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
`default_nettype wire
